// File: rtl/seg7_msg_sequencer.sv
// Character-index sequencer for the seven-segment letter decoder.
// Latency: registered outputs; start sampled at edge N gives counter=MSG_FIRST from cycle N+1.
// Backpressure: pause freezes timer/state/counter; stop aborts to IDLE and overrides pause.
//
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   start, stop     - begin playback (IDLE only) / abort playback
//   pause           - hold timer and displayed index while high (SHOW/GAP only)
//   loop_en         - wrap MSG_LAST -> MSG_FIRST instead of finishing
//   speed           - dwell scale, effective dwell = DWELL_CYCLES << speed
//   counter         - character index to the decoder (0 = blank)
//   busy            - high while in SHOW or GAP
//   done            - one-cycle pulse when a one-shot playback completes
module seg7_msg_sequencer #(
  parameter int DWELL_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int MSG_FIRST    = 1,
  parameter int MSG_LAST     = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       loop_en,
  input  logic [1:0] speed,
  output logic [3:0] counter,
  output logic       busy,
  output logic       done
);

  localparam int TMAX = ((DWELL_CYCLES << 3) > GAP_CYCLES) ? (DWELL_CYCLES << 3) : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [3:0]    FIRST_IDX = 4'(MSG_FIRST);
  localparam logic [3:0]    LAST_IDX  = 4'(MSG_LAST);
  localparam logic [TW-1:0] T_ONE     = TW'(1);
  localparam logic [TW-1:0] DWELL_BASE = TW'(DWELL_CYCLES);
  // Only meaningful when GAP_CYCLES > 0; GAP is never entered otherwise.
  localparam logic [TW-1:0] GAP_LAST  = TW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SHOW = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [TW-1:0] dwell_q, dwell_d;
  logic [3:0]    counter_q, counter_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [3:0]    next_idx;
  logic [TW-1:0] dwell_eff;

  always_comb begin
    next_idx  = (idx_q == LAST_IDX) ? FIRST_IDX : (idx_q + 4'd1);
    dwell_eff = DWELL_BASE << speed;

    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    dwell_d = dwell_q;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_SHOW;
          idx_d   = FIRST_IDX;
          timer_d = '0;
          dwell_d = dwell_eff;
        end
      end

      S_SHOW: begin
        if (stop) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else if (!pause) begin
          if (timer_q == dwell_q - T_ONE) begin
            timer_d = '0;
            if (idx_q == LAST_IDX && !loop_en) begin
              state_d = S_DONE;
            end else if (GAP_CYCLES > 0) begin
              state_d = S_GAP;
            end else begin
              // No gap: next character starts immediately with a fresh dwell.
              state_d = S_SHOW;
              idx_d   = next_idx;
              dwell_d = dwell_eff;
            end
          end else begin
            timer_d = timer_q + T_ONE;
          end
        end
      end

      S_GAP: begin
        if (stop) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else if (!pause) begin
          if (timer_q == GAP_LAST) begin
            timer_d = '0;
            state_d = S_SHOW;
            idx_d   = next_idx;
            dwell_d = dwell_eff;
          end else begin
            timer_d = timer_q + T_ONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are a function of the next state so they register in step with it.
    counter_d = (state_d == S_SHOW) ? idx_d : 4'd0;
    busy_d    = (state_d == S_SHOW) || (state_d == S_GAP);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      timer_q   <= '0;
      dwell_q   <= '0;
      counter_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      dwell_q   <= dwell_d;
      counter_q <= counter_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign counter = counter_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seg7_msg_sequencer.sv
// Self-checking bench for seg7_msg_sequencer with default parameters.
// Latency: each step drives inputs, pushes the expected post-edge outputs, then pops and compares.
// Backpressure: none; all sequences run for fixed cycle counts.
module tb_seg7_msg_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       loop_en = 1'b0;
  logic [1:0] speed = 2'd0;
  logic [3:0] counter;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_msg_sequencer dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .pause   (pause),
    .loop_en (loop_en),
    .speed   (speed),
    .counter (counter),
    .busy    (busy),
    .done    (done)
  );

  typedef struct {
    logic [3:0] counter;
    logic       busy;
    logic       done;
    string      name;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       st;
    logic       sp;
    logic       pa;
    logic [3:0] e_counter;
    logic       e_busy;
    logic       e_done;
    string      name;
  } vec_t;

  exp_t sb[$];

  // Drive one cycle of inputs, queue the expectation, clock, then compare.
  task automatic step(input logic rst, input logic st, input logic sp, input logic pa,
                      input logic lp, input logic [1:0] spd,
                      input logic [3:0] ec, input logic eb, input logic ed, input string name);
    exp_t e;
    reset   = rst;
    start   = st;
    stop    = sp;
    pause   = pa;
    loop_en = lp;
    speed   = spd;
    e.counter = ec;
    e.busy    = eb;
    e.done    = ed;
    e.name    = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      if (counter !== e.counter || busy !== e.busy || done !== e.done) begin
        errors++;
        $display("FAIL %s: got counter=%0d busy=%0b done=%0b, expected counter=%0d busy=%0b done=%0b",
                 e.name, counter, busy, done, e.counter, e.busy, e.done);
      end
    end
  endtask

  // Default-parameter playback timeline: cycle c counted from the start edge (c=1 first shown).
  // Each character occupies 4 shown + 2 blank cycles; one-shot ends with done at 41.
  function automatic exp_t play_exp(input int c, input bit lp);
    exp_t e;
    int m;
    e.counter = 4'd0;
    e.busy    = 1'b0;
    e.done    = 1'b0;
    e.name    = "";
    if (c < 1) return e;
    if (!lp && c == 41) begin
      e.done = 1'b1;
      return e;
    end
    if (!lp && c > 41) return e;
    m = (c - 1) % 42;
    e.busy = 1'b1;
    if ((m % 6) < 4) e.counter = 4'((m / 6) + 1);
    return e;
  endfunction

  vec_t vecs[21];
  exp_t x;
  int   ec;

  initial begin
    // rst st sp pa -> counter busy done
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, "reset_state"};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, "idle_hold"};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, "start_stop_same"};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, "idle_after_both"};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, "start_c1"};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, "show_c2"};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, "show_c3"};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, "start_busy_ignored"};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, "gap_c5"};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, "stop_in_gap"};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, "idle_after_stop"};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0, "start_during_pause"};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0, "paused_hold"};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, "resume_1"};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, "resume_2"};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, "resume_3"};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, "gap_after_pause"};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, "stop_over_pause"};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, "restart_c1"};
    vecs[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, "reset_mid_run"};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, "idle_after_reset"};

    @(posedge clk);
    #1;

    for (int i = 0; i < 21; i++) begin
      step(vecs[i].rst, vecs[i].st, vecs[i].sp, vecs[i].pa, 1'b0, 2'd0,
           vecs[i].e_counter, vecs[i].e_busy, vecs[i].e_done, vecs[i].name);
    end

    // One-shot run; start during DONE (sampled at end of cycle 41) must be ignored.
    for (int c = 1; c <= 43; c++) begin
      x = play_exp(c, 1'b0);
      step(1'b0, (c == 1) || (c == 42), 1'b0, 1'b0, 1'b0, 2'd0,
           x.counter, x.busy, x.done, $sformatf("oneshot_c%0d", c));
    end

    // Looping run: wraps through a gap back to character 1, never pulses done.
    for (int c = 1; c <= 46; c++) begin
      x = play_exp(c, 1'b1);
      step(1'b0, c == 1, 1'b0, 1'b0, 1'b1, 2'd0,
           x.counter, x.busy, x.done, $sformatf("loop_c%0d", c));
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 4'd0, 1'b0, 1'b0, "loop_stop");

    // Pause high in cycles 14..18: character 3 spans 13..21, everything after shifts by 5.
    for (int c = 1; c <= 47; c++) begin
      ec = (c < 14) ? c : ((c <= 18) ? 13 : c - 5);
      x = play_exp(ec, 1'b0);
      step(1'b0, c == 1, 1'b0, (c - 1 >= 14) && (c - 1 <= 18), 1'b0, 2'd0,
           x.counter, x.busy, x.done, $sformatf("pause_c%0d", c));
    end

    // speed=2 gives 16-cycle dwell; dropping to 0 mid-character applies from character 2.
    for (int c = 1; c <= 26; c++) begin
      if (c <= 16)      x.counter = 4'd1;
      else if (c <= 18) x.counter = 4'd0;
      else if (c <= 22) x.counter = 4'd2;
      else if (c <= 24) x.counter = 4'd0;
      else              x.counter = 4'd3;
      step(1'b0, c == 1, 1'b0, 1'b0, 1'b0, (c <= 5) ? 2'd2 : 2'd0,
           x.counter, 1'b1, 1'b0, $sformatf("speed_c%0d", c));
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, "speed_stop");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
